// File: rtl/lsu_pkg.sv
// Shared constants, FSM state type and size helper for the load/store aligner.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    ACC1,
    RESP
  } lsu_state_e;

  // Access size in bytes; funct3[2] only selects zero-extension.
  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store data/mask placement across two words
// and load byte selection with sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] wdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  size_i,
  input  logic [2:0]  funct3_i,
  input  logic [63:0] rdata_i,
  output logic [63:0] lane_o,
  output logic [7:0]  mask_o,
  output logic [31:0] ldata_o
);

  logic [7:0]  base_mask;
  logic [31:0] raw;

  always_comb begin
    case (size_i)
      3'd1:    base_mask = 8'h01;
      3'd2:    base_mask = 8'h03;
      default: base_mask = 8'h0F;
    endcase
    mask_o = base_mask << off_i;
    lane_o = {32'h0, wdata_i} << {off_i, 3'b000};
  end

  always_comb begin
    raw = 32'(rdata_i >> {off_i, 3'b000});
    case (funct3_i)
      F3_B:    ldata_o = {{24{raw[7]}}, raw[7:0]};
      F3_H:    ldata_o = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   ldata_o = {24'h0, raw[7:0]};
      F3_HU:   ldata_o = {16'h0, raw[15:0]};
      default: ldata_o = raw;
    endcase
  end

endmodule

// File: rtl/lsu_align_ctrl.sv
// RV32 load/store sequencer: splits word-crossing accesses into two memory cycles.
// Build option: define LSU_MISALIGN_TRAP_EN to report misaligned accesses as errors.
module lsu_align_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  dwe,
  input  logic [31:0] drdata
);

  lsu_state_e  state_q, state_d;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [2:0]  size_q;
  logic        cross_q;
  logic [29:0] word0_q;
  logic [31:0] wdata_q;
  logic [31:0] rd0_q, rd0_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  logic [1:0]  req_off;
  logic [2:0]  req_size;
  logic        req_cross;
  logic [29:0] req_word0, req_word1;
  logic        req_illegal, req_oor, req_misalign, req_bad;

  logic [63:0] rdata64, lane64;
  logic [7:0]  mask8;
  logic [31:0] ldata;

  always_comb begin
    req_off   = req_addr[1:0];
    req_size  = size_of(req_funct3);
    req_cross = ({1'b0, req_off} + req_size) > 3'd4;
    req_word0 = req_addr[31:2];
    req_word1 = req_word0 + 30'd1;
    if (req_store) req_illegal = req_funct3 > F3_W;
    else           req_illegal = (req_funct3 == 3'd3) || (req_funct3 >= 3'd6);
    req_oor = ({2'b00, req_word0} >= DMEM_WORDS) ||
              (req_cross && ({2'b00, req_word1} >= DMEM_WORDS));
`ifdef LSU_MISALIGN_TRAP_EN
    case (req_size)
      3'd2:    req_misalign = req_off[0];
      3'd4:    req_misalign = |req_off;
      default: req_misalign = 1'b0;
    endcase
`else
    req_misalign = 1'b0;
`endif
    req_bad = req_illegal || req_oor || req_misalign;
  end

  // Second cycle merges the live upper word with the byte(s) captured in ACC0.
  assign rdata64 = (state_q == ACC1) ? {drdata, rd0_q} : {32'h0, drdata};

  lsu_lane_align u_lane (
    .wdata_i (wdata_q),
    .off_i   (off_q),
    .size_i  (size_q),
    .funct3_i(f3_q),
    .rdata_i (rdata64),
    .lane_o  (lane64),
    .mask_o  (mask8),
    .ldata_o (ldata)
  );

  always_comb begin
    state_d    = state_q;
    rd0_d      = rd0_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    daddr      = '0;
    dwdata     = '0;
    dwe        = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_bad) begin
            state_d    = RESP;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end else begin
            state_d = ACC0;
          end
        end
      end
      ACC0: begin
        daddr  = {word0_q, 2'b00};
        dwdata = lane64[31:0];
        dwe    = store_q ? mask8[3:0] : 4'h0;
        rd0_d  = drdata;
        if (cross_q) begin
          state_d = ACC1;
        end else begin
          state_d    = RESP;
          rsp_err_d  = 1'b0;
          rsp_data_d = store_q ? 32'h0 : ldata;
        end
      end
      ACC1: begin
        daddr      = {word0_q + 30'd1, 2'b00};
        dwdata     = lane64[63:32];
        dwe        = store_q ? mask8[7:4] : 4'h0;
        state_d    = RESP;
        rsp_err_d  = 1'b0;
        rsp_data_d = store_q ? 32'h0 : ldata;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      store_q    <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      size_q     <= '0;
      cross_q    <= 1'b0;
      word0_q    <= '0;
      wdata_q    <= '0;
      rd0_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd0_q      <= rd0_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      if (req_valid && req_ready) begin
        store_q <= req_store;
        f3_q    <= req_funct3;
        off_q   <= req_off;
        size_q  <= req_size;
        cross_q <= req_cross;
        word0_q <= req_word0;
        wdata_q <= req_wdata;
      end
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_lsu_align_ctrl.sv
// Self-checking bench for lsu_align_ctrl against a byte-addressed reference memory.
module tb_lsu_align_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data, daddr, dwdata, drdata;
  logic [3:0]  dwe;

  always #5 clk = ~clk;

  lsu_align_ctrl #(.DMEM_WORDS(4096)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_store (req_store),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .daddr     (daddr),
    .dwdata    (dwdata),
    .dwe       (dwe),
    .drdata    (drdata)
  );

  logic [31:0] mem  [0:4095];
  logic [7:0]  refb [0:16383];

  assign drdata = (daddr[31:14] == '0) ? mem[daddr[13:2]] : 32'h0;

  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (dwe[i] && daddr[31:14] == '0)
        mem[daddr[13:2]][8*i +: 8] <= dwdata[8*i +: 8];

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preset(input int w, input logic [31:0] v);
    mem[w] = v;
    for (int i = 0; i < 4; i++) refb[4*w + i] = v[8*i +: 8];
  endtask

  // Reference: byte-by-byte little-endian access on the reference memory.
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] d, output logic e,
                       output int lat);
    int          sz;
    logic        legal;
    logic [31:0] b, v;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sz    = 1 << f3[1:0];
    e     = !legal;
    d     = 32'h0;
    if (legal)
      for (int i = 0; i < sz; i++) begin
        b = a + 32'(i);
        if (b[31:2] >= 30'd4096) e = 1'b1;
      end
`ifdef LSU_MISALIGN_TRAP_EN
    if (legal && (a % sz) != 0) e = 1'b1;
`endif
    lat = e ? 1 : ((int'(a[1:0]) + sz > 4) ? 3 : 2);
    if (!e) begin
      v = 32'h0;
      for (int i = 0; i < sz; i++) begin
        b = a + 32'(i);
        if (st) refb[b[13:0]] = wd[8*i +: 8];
        else    v = v | (32'(refb[b[13:0]]) << (8*i));
      end
      if (!st) begin
        if (f3 == 3'd0)      d = {{24{v[7]}}, v[7:0]};
        else if (f3 == 3'd1) d = {{16{v[15]}}, v[15:0]};
        else                 d = v;
      end
    end
  endtask

  logic [31:0] tr_daddr [1:3];
  logic [31:0] tr_dwdata[1:3];
  logic [3:0]  tr_dwe   [1:3];

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rdat,
                        output logic rerr, output int lat, output logic wrote);
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    for (int w = 0; w < 10 && !req_ready; w++) @(negedge clk);
    if (!req_ready) chk("ready_wait", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; wrote = 1'b0; rdat = 32'h0; rerr = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tr_daddr[k] = '0; tr_dwdata[k] = '0; tr_dwe[k] = '0;
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (dwe != 4'h0) wrote = 1'b1;
      if (k <= 3) begin
        tr_daddr[k] = daddr; tr_dwdata[k] = dwdata; tr_dwe[k] = dwe;
      end
      if (rsp_valid) begin
        lat = k; rdat = rsp_data; rerr = rsp_err;
        break;
      end
    end
  endtask

  task automatic txn(input string tag, input logic st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] gd, output logic ge);
    logic [31:0] ed;
    logic        ee, gw;
    int          el, gl;
    model(st, f3, a, wd, ed, ee, el);
    do_req(st, f3, a, wd, gd, ge, gl, gw);
    chk({tag, "_data"}, gd, ed);
    chk({tag, "_err"}, 32'(ge), 32'(ee));
    chk({tag, "_lat"}, 32'(gl), 32'(el));
    chk({tag, "_wr"}, 32'(gw), 32'(st && !ee));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] gd;
    logic        ge;
    int          mism, nrsp;

    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    for (int w = 0; w < 4096; w++) preset(w, (32'(w) * 32'h01000193) ^ 32'h5A5A5A5A);
    #2;
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_dwe", 32'(dwe), 32'h0);
    chk("rst_daddr", daddr, 32'h0);
    chk("rst_dwdata", dwdata, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    txn("sw10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, gd, ge);
    chk("sw10_daddr", tr_daddr[1], 32'h10);
    chk("sw10_dwe", 32'(tr_dwe[1]), 32'hF);
    txn("lw10", 1'b0, 3'd2, 32'h10, 32'h0, gd, ge);
    chk("lw10_val", gd, 32'hDEADBEEF);

    preset(8, 32'h80FF7F01);
    txn("lb23", 1'b0, 3'd0, 32'h23, 32'h0, gd, ge);
    chk("lb23_val", gd, 32'hFFFFFF80);
    txn("lbu23", 1'b0, 3'd4, 32'h23, 32'h0, gd, ge);
    chk("lbu23_val", gd, 32'h00000080);
    txn("lh22", 1'b0, 3'd1, 32'h22, 32'h0, gd, ge);
    chk("lh22_val", gd, 32'hFFFF80FF);
    txn("lhu20", 1'b0, 3'd5, 32'h20, 32'h0, gd, ge);
    chk("lhu20_val", gd, 32'h00007F01);

`ifndef LSU_MISALIGN_TRAP_EN
    txn("sw1e", 1'b1, 3'd2, 32'h1E, 32'h11223344, gd, ge);
    chk("sw1e_a0", tr_daddr[1], 32'h1C);
    chk("sw1e_m0", 32'(tr_dwe[1]), 32'hC);
    chk("sw1e_d0", 32'(tr_dwdata[1][31:16]), 32'h3344);
    chk("sw1e_a1", tr_daddr[2], 32'h20);
    chk("sw1e_m1", 32'(tr_dwe[2]), 32'h3);
    chk("sw1e_d1", 32'(tr_dwdata[2][15:0]), 32'h1122);
    txn("lw1e", 1'b0, 3'd2, 32'h1E, 32'h0, gd, ge);
    chk("lw1e_val", gd, 32'h11223344);

    preset(7, 32'hAAAA5555);
    preset(8, 32'h0BADF00D);
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h1E; req_wdata = 32'h11223344;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_acc1_dwe", 32'(dwe), 32'h3);
    reset = 1'b1;
    #1;
    chk("rst_async_dwe", 32'(dwe), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_rel_ready", 32'(req_ready), 32'h1);
    chk("rst_word0", mem[7], 32'h33445555);
    chk("rst_word1", mem[8], 32'h0BADF00D);
    refb[32'h1E] = 8'h44;
    refb[32'h1F] = 8'h33;
    txn("lw1c", 1'b0, 3'd2, 32'h1C, 32'h0, gd, ge);
`else
    txn("lh21", 1'b0, 3'd1, 32'h21, 32'h0, gd, ge);
    chk("lh21_err", 32'(ge), 32'h1);
`endif

    txn("ld_f3_3", 1'b0, 3'd3, 32'h10, 32'h0, gd, ge);
    chk("ld_f3_3_err", 32'(ge), 32'h1);
    txn("lw_oor", 1'b0, 3'd2, 32'h4000, 32'h0, gd, ge);
    chk("lw_oor_err", 32'(ge), 32'h1);

    // Held request: aligned load repeats every three cycles.
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
    mism = 0; nrsp = 0;
    for (int c = 0; c < 12; c++) begin
      if (req_ready !== (c % 3 == 0)) mism++;
      if (rsp_valid !== (c % 3 == 2)) mism++;
      if (rsp_valid) begin
        nrsp++;
        if (rsp_data !== 32'hDEADBEEF) mism++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b_pattern", 32'(mism), 32'h0);
    chk("b2b_rsp_count", 32'(nrsp), 32'h4);

    for (int n = 0; n < 300; n++) begin
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      int          sel;
      st  = 1'($urandom_range(0, 1));
      if (st) f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      else    f3 = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      if (sel < 7)      a = 32'($urandom_range(0, 255));
      else if (sel < 9) a = 32'h3FF0 + 32'($urandom_range(0, 31));
      else              a = $urandom;
      txn("rnd", st, f3, a, $urandom, gd, ge);
    end

    mism = 0;
    for (int w = 0; w < 4096; w++)
      if (mem[w] !== {refb[4*w+3], refb[4*w+2], refb[4*w+1], refb[4*w]}) mism++;
    chk("mem_final", 32'(mism), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
